pmod_ad1_spi_rx: RTL
====================

# pmod_ad1_spi_rx

Serial front end for the PmodAD1 (two AD7476A channels sharing CS and SCLK). It generates SCLK and CS from the system clock and shifts in both SDATA lines in parallel. Each frame yields a pair of 12-bit samples with a one-cycle valid strobe. It sits directly upstream of the sample-latching stage, which consumes DATA1/DATA2 and feeds the drum-hit logic.

## Interface
- CLK_DIV, 3: SCLK half-period in CLK cycles; legal range ≥1. 100 MHz CLK gives 16.67 MHz SCLK.
- QUIET_CYCLES, 8: minimum CS-high time between frames, in CLK cycles; legal range ≥1.
- CLK  in  1  system clock; all logic runs on its rising edge.
- RST_N  in  1  synchronous, active-low reset.
- EN  in  1  level enable for continuous conversion.
- SDATA1  in  1  serial data from ADC channel 1.
- SDATA2  in  1  serial data from ADC channel 2.
- SCLK  out  1  ADC serial clock; idles high.
- CS  out  1  ADC chip select, active-low.
- DATA1  out  12  last channel-1 sample, unsigned.
- DATA2  out  12  last channel-2 sample, unsigned.
- VALID  out  1  one-CLK pulse; DATA1/DATA2 updated this cycle.
- FRAME_ERR  out  1  leading-zero check result for the frame flagged by VALID.

## Operation
- All outputs are registered.
- Reset values: CS=1, SCLK=1, DATA1=0, DATA2=0, VALID=0, FRAME_ERR=0. After reset, the state is QUIET with the counter cleared.
- FSM states:
  - IDLE: CS=1, SCLK=1. Moves to CONV on the edge where EN=1.
  - QUIET: CS=1, SCLK=1. Counts QUIET_CYCLES. At the end, moves to CONV if EN=1, else IDLE.
  - CONV: CS=0. The divider toggles SCLK every CLK_DIV cycles, and the frame is 16 SCLK periods.
  - DONE: one cycle. Loads the outputs, pulses VALID, then enters QUIET.
- Sampling happens on the CLK edge that drives SCLK from 0 to 1. On that edge, SDATA1 and SDATA2 are shifted MSB-first into two 16-bit shift registers, and the bit counter increments.
- Frame format per channel: 4 leading zeros followed by D11..D0. DATAx receives shift-register bits [11:0].
- FRAME_ERR=1 when bits [15:12] of either channel are nonzero. DATA1/DATA2 are still updated in that case. FRAME_ERR holds until the next VALID.
- EN is sampled only in IDLE and at the end of QUIET. When EN drops during CONV, the frame completes normally, including VALID, and the FSM then goes to IDLE via QUIET.
- RST_N low in any state, including mid-CONV, forces the reset values on the next edge. The partial frame is discarded and VALID is not asserted.

## Timing
- Let t0 be the first cycle with CS=0. SCLK is high for t0..t0+CLK_DIV-1, then low for CLK_DIV cycles, and the pattern repeats.
- The k-th rising SCLK edge (k=1..16) occurs at t0+2k·CLK_DIV. That edge captures bit 16−k.
- CS returns to 1 on the same edge as the 16th rising SCLK edge, at t0+32·CLK_DIV. SCLK remains high afterwards.
- VALID=1, with the new DATA1, DATA2 and FRAME_ERR, appears in cycle t0+32·CLK_DIV+1, for exactly one cycle.
- The next CS falling edge comes QUIET_CYCLES cycles after CS rises, provided EN=1.
- Frame period is 32·CLK_DIV+QUIET_CYCLES. Defaults give 104 cycles, about 961 kSPS at 100 MHz.
- CS-high time is never less than QUIET_CYCLES, including the first frame after reset.
- From IDLE, CS falls one cycle after EN is seen high.

## Test plan
- **Default parameters, EN=1, ADC model driving 0x0A5C / 0x0FFF:**
  - Expect CS low for 96 cycles and 16 SCLK periods of 6 cycles each.
  - Expect VALID one cycle after CS rises, with DATA1=0xA5C, DATA2=0xFFF, FRAME_ERR=0.
  - Expect consecutive VALIDs exactly 104 cycles apart.
- **Model drives a leading bit of 1 on channel 2** (word 0x8123): DATA2=0x123 and FRAME_ERR=1 with that VALID. The next clean frame clears FRAME_ERR to 0.
- **EN deasserted at cycle t0+40:**
  - Expect the frame to finish with VALID.
  - Expect CS to stay 1 and SCLK to stay 1 in IDLE.
  - Re-asserting EN makes CS fall one cycle later.
- **RST_N low for one cycle at t0+50:**
  - Next cycle shows CS=1, SCLK=1, DATA=0, VALID=0.
  - There is no VALID for the aborted frame.
  - The next CS fall comes after QUIET_CYCLES, and the new frame decodes correctly.
- **CLK_DIV=1, QUIET_CYCLES=1, data 0x0001 / 0x0800:**
  - SCLK toggles every cycle and the frame period is 33 cycles.
  - DATA1=0x001, DATA2=0x800.
- **Alternating-bit pattern 0x0AAA / 0x0555 over 10 back-to-back frames:** every VALID carries exactly those values. There are no extra or missing VALID pulses.

Source files
------------

// File: rtl/pmod_ad1_spi_rx.sv
// pmod_ad1_spi_rx
//   SPI receive front end for the PmodAD1 (two AD7476A ADCs that share CS
//   and SCLK). It generates SCLK/CS from clk_i, shifts both SDATA lines in
//   parallel and delivers a pair of 12-bit samples per frame with a
//   one-cycle valid strobe.
//
// Parameters
//   CLK_DIV      SCLK half-period in clk_i cycles (>=1)
//   QUIET_CYCLES minimum CS-high time between frames in clk_i cycles (>=1)
//
// Ports
//   clk_i        system clock, rising edge
//   rst_n_i      synchronous active-low reset
//   en_i         level enable for continuous conversion
//   sdata1_i     serial data, ADC channel 1
//   sdata2_i     serial data, ADC channel 2
//   sclk_o       ADC serial clock, idles high
//   cs_o         ADC chip select, active low
//   data1_o      last channel-1 sample (12-bit unsigned)
//   data2_o      last channel-2 sample (12-bit unsigned)
//   valid_o      one-cycle pulse, data1_o/data2_o updated this cycle
//   frame_err_o  leading-zero check failed for the frame flagged by valid_o
module pmod_ad1_spi_rx #(
  parameter int CLK_DIV      = 3,
  parameter int QUIET_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        sdata1_i,
  input  logic        sdata2_i,
  output logic        sclk_o,
  output logic        cs_o,
  output logic [11:0] data1_o,
  output logic [11:0] data2_o,
  output logic        valid_o,
  output logic        frame_err_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int QW    = $clog2(QUIET_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, QUIET, CONV, DONE} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      sh1_q, sh1_d, sh2_q, sh2_d;
  logic             sclk_q, sclk_d, cs_q, cs_d;
  logic [11:0]      d1_q, d1_d, d2_q, d2_d;
  logic             valid_q, valid_d, ferr_q, ferr_d;
  logic             div_end, quiet_end, start_conv;

  assign div_end   = (div_q == DIV_W'(CLK_DIV - 1));
  assign quiet_end = (qcnt_q == QW'(QUIET_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qcnt_d     = qcnt_q;
    bit_d      = bit_q;
    sh1_d      = sh1_q;
    sh2_d      = sh2_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;
    start_conv = 1'b0;

    unique case (state_q)
      IDLE: start_conv = en_i;

      // qcnt counts CS-high cycles; it starts at 1 after DONE because the
      // DONE cycle itself already has CS high.
      QUIET: begin
        if (quiet_end) begin
          if (en_i) start_conv = 1'b1;
          else      state_d    = IDLE;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end

      CONV: begin
        if (div_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // The edge that raises SCLK is the sampling edge.
          if (!sclk_q) begin
            sh1_d = {sh1_q[14:0], sdata1_i};
            sh2_d = {sh2_q[14:0], sdata2_i};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd15) begin
              state_d = DONE;
              cs_d    = 1'b1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      DONE: begin
        d1_d    = sh1_q[11:0];
        d2_d    = sh2_q[11:0];
        ferr_d  = (|sh1_q[15:12]) | (|sh2_q[15:12]);
        valid_d = 1'b1;
        // With a one-cycle quiet time the DONE cycle is the whole gap.
        if (QUIET_CYCLES == 1) begin
          if (en_i) start_conv = 1'b1;
          else      state_d    = IDLE;
        end else begin
          state_d = QUIET;
          qcnt_d  = QW'(1);
        end
      end

      default: state_d = QUIET;
    endcase

    if (start_conv) begin
      state_d = CONV;
      cs_d    = 1'b0;
      sclk_d  = 1'b1;
      div_d   = '0;
      bit_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= QUIET;
      div_q   <= '0;
      qcnt_q  <= '0;
      bit_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sclk_q  <= 1'b1;
      cs_q    <= 1'b1;
      d1_q    <= '0;
      d2_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qcnt_q  <= qcnt_d;
      bit_q   <= bit_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign sclk_o      = sclk_q;
  assign cs_o        = cs_q;
  assign data1_o     = d1_q;
  assign data2_o     = d2_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule
